// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial frame receiver:
//   - rx_state_t : receiver FSM state encoding (IDLE/DATA/PARITY/STOP)
//   - START_BIT / STOP_BIT : line levels that mark frame boundaries
//   - clog2()    : ceiling log2, used to size the bit counter
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Ceiling log2; clog2(1) = 0. The counter must reach DATA_W,
  // so callers pass DATA_W+1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// ---------------------------------------------------------------------------
// rx_hold_reg
// Holding register between the frame receiver and its consumer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : a good frame completed this cycle; din carries its payload
//   din        : payload of the completed frame
//   ack        : consumer accepts dout (ignored while valid is low)
//   ovr_clr    : clears the sticky overrun flag
//   dout       : held payload
//   valid      : dout holds an unacknowledged byte
//   overrun    : sticky, a good frame arrived while the register was full
// ---------------------------------------------------------------------------
module rx_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ack,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              overrun_reg, overrun_next;
  logic              hold_free;

  // An ack in the same cycle as a new frame frees the slot, so the new
  // byte replaces the acknowledged one without a gap in valid.
  assign hold_free = !valid_reg || ack;

  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;

    if (load && hold_free) begin
      data_next  = din;
      valid_next = 1'b1;
    end else if (ack && valid_reg) begin
      valid_next = 1'b0;
    end

    // A new overrun wins over a simultaneous clear.
    if (load && !hold_free) begin
      overrun_next = 1'b1;
    end else if (ovr_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign dout    = data_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver
// Receives frames of the form: start(0), DATA_W payload bits MSB first,
// optional even-parity bit, stop(1). One frame bit is consumed per cycle
// with BitEn=1; all state holds on cycles with BitEn=0.
// Ports:
//   Clk, Reset : clock, asynchronous active-high reset
//   SerIn      : serial bit stream
//   BitEn      : bit strobe, SerIn is sampled only when high
//   DataOut    : received payload (holding register)
//   DataValid  : DataOut holds an unacknowledged byte
//   DataAck    : consumer accepts DataOut
//   FrameErr   : one-cycle pulse, stop bit was 0
//   ParityErr  : one-cycle pulse, parity mismatch
//   Overrun    : sticky, good frame arrived while holding register was full
//   OvrClr     : clears Overrun
//   Busy       : FSM is not in IDLE
// ---------------------------------------------------------------------------
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SerIn,
  input  logic              BitEn,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  input  logic              DataAck,
  output logic              FrameErr,
  output logic              ParityErr,
  output logic              Overrun,
  input  logic              OvrClr,
  output logic              Busy
);

  localparam int                CNT_W    = clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  rx_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic              perr_reg, perr_next;
  logic              frame_err_reg, frame_err_next;
  logic              parity_err_reg, parity_err_next;
  logic              good_frame;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shreg_next      = shreg_reg;
    perr_next       = perr_reg;
    // Error flags default low so they only ever last one cycle.
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    good_frame      = 1'b0;

    if (BitEn) begin
      case (state_reg)
        IDLE: begin
          if (SerIn == START_BIT) begin
            state_next = DATA;
            cnt_next   = '0;
            // Drop any parity verdict left over from the previous frame.
            perr_next  = 1'b0;
          end
        end
        DATA: begin
          shreg_next = {shreg_reg[DATA_W-2:0], SerIn};
          cnt_next   = cnt_reg + CNT_ONE;
          if (cnt_reg == LAST_CNT) begin
            state_next = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          // Even parity: payload XOR parity bit must be 0.
          perr_next  = PARITY_EN & ((^shreg_reg) ^ SerIn);
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // A bad stop bit masks any parity verdict.
          if (SerIn != STOP_BIT) begin
            frame_err_next = 1'b1;
          end else if (perr_reg) begin
            parity_err_next = 1'b1;
          end else begin
            good_frame = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shreg_reg      <= '0;
      perr_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shreg_reg      <= shreg_next;
      perr_reg       <= perr_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
    end
  end

  // shreg_reg holds the complete payload throughout STOP, so it can be
  // handed to the holding register on the stop-bit edge directly.
  rx_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (Clk),
    .rst     (Reset),
    .load    (good_frame),
    .din     (shreg_reg),
    .ack     (DataAck),
    .ovr_clr (OvrClr),
    .dout    (DataOut),
    .valid   (DataValid),
    .overrun (Overrun)
  );

  assign FrameErr  = frame_err_reg;
  assign ParityErr = parity_err_reg;
  assign Busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_receiver
// Two receivers share clock and reset: u_dut0 without parity, u_dut1 with
// even parity. Stimulus pushes the expected event (byte, frame error or
// parity error) into a per-instance queue; a negedge monitor pops and
// compares whenever the DUT presents a new byte or an error pulse.
// Directed spot checks are made from the stimulus thread as well.
// ---------------------------------------------------------------------------
module tb_serial_frame_receiver;

  localparam logic [1:0] K_DATA = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_PERR = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       serin0, biten0, ack0, ovrclr0;
  logic [7:0] dout0;
  logic       valid0, ferr0, perr0, ovr0, busy0;
  logic       serin1, biten1, ack1, ovrclr1;
  logic [7:0] dout1;
  logic       valid1, ferr1, perr1, ovr1, busy1;

  serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b0)) u_dut0 (
    .Clk(clk), .Reset(rst), .SerIn(serin0), .BitEn(biten0),
    .DataOut(dout0), .DataValid(valid0), .DataAck(ack0),
    .FrameErr(ferr0), .ParityErr(perr0), .Overrun(ovr0),
    .OvrClr(ovrclr0), .Busy(busy0)
  );

  serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b1)) u_dut1 (
    .Clk(clk), .Reset(rst), .SerIn(serin1), .BitEn(biten1),
    .DataOut(dout1), .DataValid(valid1), .DataAck(ack1),
    .FrameErr(ferr1), .ParityErr(perr1), .Overrun(ovr1),
    .OvrClr(ovrclr1), .Busy(busy1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [1:0] k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] pdout  [2];
  logic       pvalid [2];
  logic       pferr  [2];
  logic       pperr  [2];

  task automatic mon(input int inst, input logic [7:0] dout, input logic valid,
                     input logic ferr, input logic perr);
    exp_t       e;
    logic [1:0] kind;
    bit         have;
    if (ferr || perr || (valid && (!pvalid[inst] || dout != pdout[inst]))) begin
      kind = ferr ? K_FERR : (perr ? K_PERR : K_DATA);
      have = (inst == 0) ? (q0.size() > 0) : (q1.size() > 0);
      n_checks++;
      if (!have) begin
        n_fail++;
        $display("FAIL mon%0d unexpected event: kind %0d data %0h, required none", inst, kind, dout);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        if (e.kind != kind || (kind == K_DATA && e.data != dout) || (ferr && perr)) begin
          n_fail++;
          $display("FAIL mon%0d event: kind %0d data %0h (ferr %0b perr %0b), required kind %0d data %0h",
                   inst, kind, dout, ferr, perr, e.kind, e.data);
        end else begin
          $display("ok   mon%0d event kind %0d data %0h", inst, kind, dout);
        end
      end
    end
    if (ferr) begin
      n_checks++;
      if (pferr[inst]) begin
        n_fail++;
        $display("FAIL mon%0d FrameErr width: high 2+ cycles, required 1", inst);
      end
    end
    if (perr) begin
      n_checks++;
      if (pperr[inst]) begin
        n_fail++;
        $display("FAIL mon%0d ParityErr width: high 2+ cycles, required 1", inst);
      end
    end
    pdout[inst]  = dout;
    pvalid[inst] = valid;
    pferr[inst]  = ferr;
    pperr[inst]  = perr;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pvalid[0] = 1'b0; pferr[0] = 1'b0; pperr[0] = 1'b0; pdout[0] = 8'h00;
      pvalid[1] = 1'b0; pferr[1] = 1'b0; pperr[1] = 1'b0; pdout[1] = 8'h00;
    end else begin
      mon(0, dout0, valid0, ferr0, perr0);
      mon(1, dout1, valid1, ferr1, perr1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic b, input logic en, input logic ack);
    if (inst == 0) begin
      serin0 = b; biten0 = en; ack0 = ack;
    end else begin
      serin1 = b; biten1 = en; ack1 = ack;
    end
  endtask

  // Present one bit for one strobed edge, then idle (with the opposite
  // level on the line, which must be ignored) for gap cycles.
  task automatic send_bit(input int inst, input logic b, input int gap, input logic ack);
    drive(inst, b, 1'b1, ack);
    sync();
    drive(inst, ~b, 1'b0, 1'b0);
    repeat (gap) sync();
  endtask

  // Returns just after the stop-bit edge.
  task automatic send_frame(input int inst, input logic [7:0] d, input logic has_par,
                            input logic par, input logic stop, input int gap,
                            input logic ack_on_stop);
    sync();
    send_bit(inst, 1'b0, gap, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(inst, d[i], gap, 1'b0);
    if (has_par) send_bit(inst, par, gap, 1'b0);
    send_bit(inst, stop, 0, ack_on_stop);
  endtask

  task automatic do_ack(input int inst);
    sync();
    if (inst == 0) ack0 = 1'b1; else ack1 = 1'b1;
    sync();
    if (inst == 0) ack0 = 1'b0; else ack1 = 1'b0;
    @(negedge clk);
    chk($sformatf("ack%0d clears DataValid", inst), {15'd0, (inst == 0) ? valid0 : valid1}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    serin0 = 1'b1; biten0 = 1'b0; ack0 = 1'b0; ovrclr0 = 1'b0;
    serin1 = 1'b1; biten1 = 1'b0; ack1 = 1'b0; ovrclr1 = 1'b0;

    @(negedge clk);
    chk("reset dout0",  {8'd0, dout0}, 16'h0000);
    chk("reset flags0", {10'd0, valid0, ferr0, perr0, ovr0, busy0, 1'b0}, 16'h0000);
    chk("reset flags1", {10'd0, valid1, ferr1, perr1, ovr1, busy1, 1'b0}, 16'h0000);
    sync();
    rst = 1'b0;
    @(negedge clk);

    // Clean frame 0x36, one cycle latency after the stop bit.
    q0.push_back(mk(K_DATA, 8'h36));
    send_frame(0, 8'h36, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("clean valid", {15'd0, valid0}, 16'd1);
    chk("clean dout",  {8'd0, dout0}, 16'h0036);
    chk("clean busy",  {14'd0, busy0, ferr0}, 16'd0);
    do_ack(0);

    // Framing error.
    q0.push_back(mk(K_FERR, 8'h00));
    send_frame(0, 8'h36, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("ferr pulse", {14'd0, ferr0, perr0}, 16'b10);
    chk("ferr valid/busy", {14'd0, valid0, busy0}, 16'd0);
    @(negedge clk);
    chk("ferr drops", {15'd0, ferr0}, 16'd0);

    // Overrun: 0x36 held, 0xC3 dropped.
    q0.push_back(mk(K_DATA, 8'h36));
    send_frame(0, 8'h36, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("ovr first valid", {15'd0, valid0}, 16'd1);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("ovr dout kept", {8'd0, dout0}, 16'h0036);
    chk("ovr flag set",  {14'd0, ovr0, valid0}, 16'b11);
    sync();
    ovrclr0 = 1'b1;
    sync();
    ovrclr0 = 1'b0;
    @(negedge clk);
    chk("ovr cleared", {15'd0, ovr0}, 16'd0);
    do_ack(0);

    // Ack collides with the stop bit of the next frame.
    q0.push_back(mk(K_DATA, 8'h11));
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    q0.push_back(mk(K_DATA, 8'h22));
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    @(negedge clk);
    chk("collide dout", {8'd0, dout0}, 16'h0022);
    chk("collide valid/ovr", {14'd0, valid0, ovr0}, 16'b10);
    do_ack(0);

    // Three idle cycles between every bit.
    q0.push_back(mk(K_DATA, 8'h5A));
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    @(negedge clk);
    chk("gap dout", {7'd0, valid0, dout0}, 16'h015A);
    do_ack(0);

    // Reset after the 4th data bit.
    sync();
    send_bit(0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("midframe busy", {15'd0, busy0}, 16'd1);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("midreset dout", {8'd0, dout0}, 16'h0000);
    chk("midreset flags", {11'd0, valid0, ferr0, perr0, ovr0, busy0}, 16'd0);
    sync();
    rst = 1'b0;
    q0.push_back(mk(K_DATA, 8'hF0));
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("post-reset dout", {7'd0, valid0, dout0}, 16'h01F0);
    do_ack(0);

    // Parity instance: 0xA5 has four ones, even parity bit is 0.
    q1.push_back(mk(K_DATA, 8'hA5));
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("par good A5", {7'd0, valid1, dout1}, 16'h01A5);
    chk("par good no perr", {15'd0, perr1}, 16'd0);
    do_ack(1);

    q1.push_back(mk(K_DATA, 8'h3C));
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("par good 3C", {7'd0, valid1, dout1}, 16'h013C);
    do_ack(1);

    q1.push_back(mk(K_PERR, 8'h00));
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("perr pulse", {14'd0, perr1, ferr1}, 16'b10);
    chk("perr dout kept", {7'd0, valid1, dout1}, 16'h003C);
    @(negedge clk);
    chk("perr drops", {15'd0, perr1}, 16'd0);

    // Bad parity and bad stop together: only the framing error shows.
    q1.push_back(mk(K_FERR, 8'h00));
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("ferr over perr", {14'd0, ferr1, perr1}, 16'b10);

    repeat (3) @(negedge clk);
    chk("q0 drained", q0.size(), 16'd0);
    chk("q1 drained", q1.size(), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
